// File: rtl/instruction_fetch.sv
// Instruction fetch unit: IDLE/FETCH/HALT sequencer driving a 2^ADDR_W-word program memory.
// Define FETCH_WRAP_EN to wrap pc at end of memory; otherwise fetching halts there.
module instruction_fetch #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              stall,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instr_in,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              halted
);

  typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

  localparam logic [ADDR_W-1:0] PcLast = {ADDR_W{1'b1}};

  state_e state;
  logic   is_halt_op;

  assign is_halt_op = (instr_in[DATA_W-1 -: 4] == HALT_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      pc          <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          instr_valid <= 1'b0;
          if (jump_req) begin
            pc    <= jump_addr;
            state <= StFetch;
          end else if (en) begin
            state <= StFetch;
          end
        end
        StFetch: begin
          // A redirect discards the word currently on instr_in.
          if (jump_req) begin
            pc          <= jump_addr;
            instr_valid <= 1'b0;
          end else if (!en) begin
            state       <= StIdle;
            instr_valid <= 1'b0;
          end else if (!stall) begin
            instr_out   <= instr_in;
            instr_valid <= 1'b1;
            if (is_halt_op) begin
              state  <= StHalt;
              halted <= 1'b1;
            end else if (pc == PcLast) begin
`ifdef FETCH_WRAP_EN
              pc <= '0;
`else
              state  <= StHalt;
              halted <= 1'b1;
`endif
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        StHalt: begin
          instr_valid <= 1'b0;
          if (jump_req) begin
            pc     <= jump_addr;
            state  <= StFetch;
            halted <= 1'b0;
          end
        end
        default: begin
          state       <= StIdle;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, hand sequences for
// halt/end-of-memory/async reset, then randomized run against a behavioural model.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, stall, jump_req;
  logic [3:0] jump_addr;
  logic [3:0] pc;
  logic [7:0] instr_in, instr_out;
  logic       instr_valid, halted;

  logic [7:0] mem [16];

  int errors = 0;
  int checks = 0;

  // Behavioural model: mode 0 = idle, 1 = fetching, 2 = halted.
  int m_pc, m_out, m_valid, m_mode;

  always #5 clk = ~clk;

  assign instr_in = mem[pc];

  instruction_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .stall      (stall),
    .jump_req   (jump_req),
    .jump_addr  (jump_addr),
    .pc         (pc),
    .instr_in   (instr_in),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .halted     (halted)
  );

  typedef struct {
    logic       en, st, jr;
    logic [3:0] ja;
    int         epc, eout, ev, eh;
  } vec_t;

  function automatic vec_t mk(input logic e, s, j, input logic [3:0] a,
                              input int epc, eout, ev, eh);
    vec_t v;
    v.en = e; v.st = s; v.jr = j; v.ja = a;
    v.epc = epc; v.eout = eout; v.ev = ev; v.eh = eh;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int epc, eout, ev, eh);
    check({tag, ".pc"}, int'(pc), epc);
    check({tag, ".instr_out"}, int'(instr_out), eout);
    check({tag, ".instr_valid"}, int'(instr_valid), ev);
    check({tag, ".halted"}, int'(halted), eh);
  endtask

  task automatic model_reset();
    m_pc = 0; m_out = 0; m_valid = 0; m_mode = 0;
  endtask

  task automatic model_step(input logic e, s, j, input logic [3:0] a);
    int word;
    word = int'(mem[m_pc]);
    if (m_mode == 0) begin
      m_valid = 0;
      if (j) begin m_pc = int'(a); m_mode = 1; end
      else if (e) m_mode = 1;
    end else if (j) begin
      m_pc = int'(a); m_valid = 0; m_mode = 1;
    end else if (m_mode == 2) begin
      m_valid = 0;
    end else if (!e) begin
      m_mode = 0; m_valid = 0;
    end else if (!s) begin
      m_out = word; m_valid = 1;
      if (word / 16 == 15) m_mode = 2;
      else if (m_pc == 15) begin
`ifdef FETCH_WRAP_EN
        m_pc = 0;
`else
        m_mode = 2;
`endif
      end else m_pc = (m_pc + 1) % 16;
    end
  endtask

  task automatic step(input logic e, s, j, input logic [3:0] a);
    en = e; stall = s; jump_req = j; jump_addr = a;
    @(posedge clk);
    model_step(e, s, j, a);
    #1;
  endtask

  vec_t tbl [13];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    en = 1'b0; stall = 1'b0; jump_req = 1'b0; jump_addr = 4'h0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset", 0, 0, 0, 0);
    #11;
    rst_n = 1'b1;

    tbl[0]  = mk(1, 0, 0, 4'h0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 0, 0, 4'h0, 1, 8'h10, 1, 0);
    tbl[2]  = mk(1, 0, 0, 4'h0, 2, 8'h11, 1, 0);
    tbl[3]  = mk(1, 0, 0, 4'h0, 3, 8'h12, 1, 0);
    tbl[4]  = mk(1, 0, 0, 4'h0, 4, 8'h13, 1, 0);
    tbl[5]  = mk(1, 0, 0, 4'h0, 5, 8'h14, 1, 0);
    tbl[6]  = mk(1, 1, 0, 4'h0, 5, 8'h14, 1, 0);
    tbl[7]  = mk(1, 1, 0, 4'h0, 5, 8'h14, 1, 0);
    tbl[8]  = mk(1, 1, 0, 4'h0, 5, 8'h14, 1, 0);
    tbl[9]  = mk(1, 0, 0, 4'h0, 6, 8'h15, 1, 0);
    tbl[10] = mk(1, 0, 1, 4'h3, 3, 8'h15, 0, 0);
    tbl[11] = mk(1, 1, 1, 4'hA, 10, 8'h15, 0, 0);
    tbl[12] = mk(1, 0, 0, 4'h0, 11, 8'h1A, 1, 0);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].en, tbl[i].st, tbl[i].jr, tbl[i].ja);
      check_all($sformatf("vec%0d", i), tbl[i].epc, tbl[i].eout, tbl[i].ev, tbl[i].eh);
    end

    // Halt opcode at word 6, then restart by jump.
    mem[6] = 8'hF0;
    step(1, 0, 1, 4'h5); check_all("h_jmp5", 5, 8'h1A, 0, 0);
    step(1, 0, 0, 4'h0); check_all("h_f5", 6, 8'h15, 1, 0);
    step(1, 0, 0, 4'h0); check_all("h_cap", 6, 8'hF0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 4'h0); check_all("h_hold", 6, 8'hF0, 0, 1);
    end
    step(1, 0, 1, 4'h0); check_all("h_jmp0", 0, 8'hF0, 0, 0);
    step(1, 0, 0, 4'h0); check_all("h_restart", 1, 8'h10, 1, 0);
    mem[6] = 8'h16;

    // en=0 from fetch drops to idle holding pc.
    step(0, 0, 0, 4'h0); check_all("idle0", 1, 8'h10, 0, 0);
    step(0, 0, 0, 4'h0); check_all("idle1", 1, 8'h10, 0, 0);

    // End of memory.
    step(1, 0, 0, 4'h0);
    step(1, 0, 1, 4'hD); check_all("e_jmp", 13, 8'h10, 0, 0);
    step(1, 0, 0, 4'h0); check_all("e_13", 14, 8'h1D, 1, 0);
    step(1, 0, 0, 4'h0); check_all("e_14", 15, 8'h1E, 1, 0);
`ifdef FETCH_WRAP_EN
    step(1, 0, 0, 4'h0); check_all("e_wrap", 0, 8'h1F, 1, 0);
    step(1, 0, 0, 4'h0); check_all("e_wrap1", 1, 8'h10, 1, 0);
`else
    step(1, 0, 0, 4'h0); check_all("e_end", 15, 8'h1F, 1, 1);
    step(1, 0, 0, 4'h0); check_all("e_endh", 15, 8'h1F, 0, 1);
`endif

    // Asynchronous reset mid-cycle at pc=9.
    step(1, 0, 1, 4'h8); check("r_jmp.pc", int'(pc), 8);
    step(1, 0, 0, 4'h0); check_all("r_pc9", 9, 8'h18, 1, 0);
    #3 rst_n = 1'b0;
    #1 check_all("r_async", 0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    check_all("r_held", 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 0, 4'h0); check_all("r_idle", 0, 0, 0, 0);
    step(1, 0, 0, 4'h0); check_all("r_first", 1, 8'h10, 1, 0);

    // Randomized run against the model.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic e, s, j;
      logic [3:0] a;
      e = ($urandom_range(0, 9) != 0);
      s = e && ($urandom_range(0, 4) == 0);
      j = (m_mode != 0) && ($urandom_range(0, 9) < ((m_mode == 2) ? 4 : 1));
      a = 4'($urandom);
      step(e, s, j, a);
      check_all($sformatf("rnd%0d", n), m_pc, m_out, m_valid, (m_mode == 2) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
